// File: rtl/ps2_matrix_scanner.sv
// PS/2 keyboard front end: clock filter, frame deframer, prefix decoder and a loadable
// scancode map that drives an active-low key matrix plus eight special outputs.
module ps2_matrix_scanner #(
  parameter int unsigned ROWS    = 10,
  parameter int unsigned COLS    = 8,
  parameter int unsigned ROWW    = 4,
  parameter int unsigned TIMEOUT = 4000
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            ce_i,
  input  logic [1:0]      ps2_i,
  input  logic            map_we_i,
  input  logic [8:0]      map_addr_i,
  input  logic [ROWW+4:0] map_data_i,
  input  logic [ROWW-1:0] row_i,
  output logic [COLS-1:0] do_o,
  output logic [7:0]      fn_o,
  output logic            key_event_o,
  output logic [9:0]      key_code_o,
  output logic            frame_err_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned EW = ROWW + 5;

  typedef enum logic [1:0] {StIdle, StLookup, StApply, StSkip} state_e;

  logic [7:0]    shift_q;
  logic          filt_q, data_q, par_q, byte_vld_q, frame_err_q;
  logic [3:0]    cnt_q;
  logic [7:0]    sr_q;
  logic [TW-1:0] to_q;
  logic          fall;

  assign fall = filt_q && (shift_q == 8'h00);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      shift_q     <= 8'hFF;
      filt_q      <= 1'b1;
      data_q      <= 1'b1;
      cnt_q       <= '0;
      sr_q        <= '0;
      par_q       <= 1'b0;
      to_q        <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else if (ce_i) begin
      shift_q     <= {shift_q[6:0], ps2_i[0]};
      data_q      <= ps2_i[1];
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (shift_q == 8'hFF) filt_q <= 1'b1;
      else if (shift_q == 8'h00) filt_q <= 1'b0;
      if (fall) begin
        to_q <= '0;
        if (cnt_q == 4'd0) begin
          if (!data_q) begin
            cnt_q <= 4'd1;
            par_q <= 1'b0;
          end
        end else if (cnt_q <= 4'd8) begin
          sr_q  <= {data_q, sr_q[7:1]};
          par_q <= par_q ^ data_q;
          cnt_q <= cnt_q + 4'd1;
        end else if (cnt_q == 4'd9) begin
          par_q <= par_q ^ data_q;
          cnt_q <= 4'd10;
        end else begin
          // par_q is the XOR of data and parity bits: 1 means odd parity held
          if (data_q && par_q) byte_vld_q <= 1'b1;
          else frame_err_q <= 1'b1;
          cnt_q <= 4'd0;
        end
      end else if ((cnt_q != 4'd0) && (to_q == TW'(TIMEOUT))) begin
        cnt_q       <= 4'd0;
        frame_err_q <= 1'b1;
      end else if (to_q != TW'(TIMEOUT)) begin
        to_q <= to_q + 1'b1;
      end
    end
  end

  state_e     state_q, state_d;
  logic       ext_q, ext_d, rel_q, rel_d, ovr;
  logic [2:0] skip_q, skip_d;
  logic [7:0] code_q, code_d;

  always_comb begin
    state_d = state_q;
    ext_d   = ext_q;
    rel_d   = rel_q;
    skip_d  = skip_q;
    code_d  = code_q;
    ovr     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (byte_vld_q) begin
          code_d = sr_q;
          case (sr_q)
            8'hE0: ext_d = 1'b1;
            8'hF0: rel_d = 1'b1;
            8'hE1: begin
              state_d = StSkip;
              skip_d  = 3'd7;
              ext_d   = 1'b0;
              rel_d   = 1'b0;
            end
            8'h00, 8'hFF: begin
              ovr   = 1'b1;
              ext_d = 1'b0;
              rel_d = 1'b0;
            end
            8'hFA, 8'hAA, 8'hEE, 8'hFE: begin
              ext_d = 1'b0;
              rel_d = 1'b0;
            end
            default: state_d = StLookup;
          endcase
        end
      end
      StLookup: state_d = StApply;
      StApply: begin
        state_d = StIdle;
        ext_d   = 1'b0;
        rel_d   = 1'b0;
      end
      StSkip: begin
        if (byte_vld_q) begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      ext_q   <= 1'b0;
      rel_q   <= 1'b0;
      skip_q  <= '0;
      code_q  <= '0;
    end else if (ce_i) begin
      state_q <= state_d;
      ext_q   <= ext_d;
      rel_q   <= rel_d;
      skip_q  <= skip_d;
      code_q  <= code_d;
    end
  end

  // Map contents survive reset; the initialiser makes every entry invalid at power-up.
  logic [EW-1:0] mem_q [512] = '{default: '0};
  logic [EW-1:0] rd_q;

  always_ff @(posedge clock_i) begin
    if (ce_i) begin
      if (map_we_i) mem_q[map_addr_i] <= map_data_i;
      if (state_q == StLookup) rd_q <= mem_q[{ext_q, code_q}];
    end
  end

  logic            rd_vld, rd_spc;
  logic [ROWW-1:0] rd_row;
  logic [2:0]      rd_col;

  assign rd_vld = rd_q[ROWW+4];
  assign rd_spc = rd_q[ROWW+3];
  assign rd_row = rd_q[ROWW+2:3];
  assign rd_col = rd_q[2:0];

  logic [COLS-1:0] mat_q [ROWS];
  logic [7:0]      fn_q;
  logic            key_event_q;
  logic [9:0]      key_code_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int r = 0; r < int'(ROWS); r++) mat_q[r] <= '1;
      fn_q        <= 8'hFF;
      key_event_q <= 1'b0;
      key_code_q  <= '0;
    end else if (ce_i) begin
      key_event_q <= 1'b0;
      if (ovr) begin
        for (int r = 0; r < int'(ROWS); r++) mat_q[r] <= '1;
        fn_q <= 8'hFF;
      end else if ((state_q == StApply) && rd_vld) begin
        key_event_q <= 1'b1;
        key_code_q  <= {rel_q, ext_q, code_q};
        if (rd_spc) fn_q[rd_col] <= rel_q;
        else if ((32'(rd_row) < ROWS) && (32'(rd_col) < COLS)) mat_q[rd_row][rd_col] <= rel_q;
      end
    end
  end

  always_comb begin
    do_o = '1;
    if (32'(row_i) < ROWS) do_o = mat_q[row_i];
  end

  assign fn_o        = fn_q;
  assign key_event_o = key_event_q;
  assign key_code_o  = key_code_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_ps2_matrix_scanner.sv
// Bench for ps2_matrix_scanner: drives PS/2 frames on the pins, scoreboards key_code
// against a queue of expected events and checks the matrix and special outputs.
module tb_ps2_matrix_scanner;

  localparam int unsigned TO = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b1;
  logic [1:0] ps2 = 2'b11;
  logic       map_we = 1'b0;
  logic [8:0] map_addr = '0;
  logic [8:0] map_data = '0;
  logic [3:0] row = '0;
  logic [7:0] do_w, fn_w;
  logic       key_event, frame_err;
  logic [9:0] key_code;

  int total = 0;
  int bad = 0;
  int ev_cnt = 0;
  int err_cnt = 0;
  logic [9:0] exp_q[$];

  ps2_matrix_scanner #(.ROWS(10), .COLS(8), .ROWW(4), .TIMEOUT(TO)) dut (
    .clock_i    (clk),
    .reset_i    (rst),
    .ce_i       (ce),
    .ps2_i      (ps2),
    .map_we_i   (map_we),
    .map_addr_i (map_addr),
    .map_data_i (map_data),
    .row_i      (row),
    .do_o       (do_w),
    .fn_o       (fn_w),
    .key_event_o(key_event),
    .key_code_o (key_code),
    .frame_err_o(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ce) begin
      if (key_event) begin
        ev_cnt++;
        if (exp_q.size() > 0) check_val("key_code", 32'(key_code), 32'(exp_q.pop_front()));
      end
      if (frame_err) err_cnt++;
    end
  end

  function automatic logic [8:0] ent(input logic v, input logic s, input logic [3:0] r,
                                     input logic [2:0] c);
    return {v, s, r, c};
  endfunction

  task automatic send_bit(input logic b);
    ps2[1] = b;
    ps2[0] = 1'b1;
    repeat (20) @(negedge clk);
    ps2[0] = 1'b0;
    repeat (20) @(negedge clk);
    ps2[0] = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(!bad_stop);
    ps2 = 2'b11;
    repeat (60) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_byte(b, 1'b0, 1'b0);
  endtask

  task automatic map_wr(input logic [8:0] a, input logic [8:0] d);
    @(negedge clk);
    map_we   = 1'b1;
    map_addr = a;
    map_data = d;
    @(negedge clk);
    map_we = 1'b0;
  endtask

  task automatic chk_row(input string tag, input logic [3:0] r, input logic [7:0] exp);
    @(negedge clk);
    row = r;
    #1;
    check_val(tag, 32'(do_w), 32'(exp));
  endtask

  int ev0, err0;

  initial begin
    repeat (5) @(negedge clk);
    chk_row("rst_do", 4'd0, 8'hFF);
    check_val("rst_fn", 32'(fn_w), 32'hFF);
    check_val("rst_kev", 32'(key_event), 0);
    check_val("rst_kcode", 32'(key_code), 0);
    check_val("rst_ferr", 32'(frame_err), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // make/break of a plain key
    map_wr(9'h01C, ent(1'b1, 1'b0, 4'd2, 3'd5));
    exp_q.push_back(10'h01C);
    send(8'h1C);
    chk_row("make_1c", 4'd2, 8'hDF);
    exp_q.push_back(10'h21C);
    send(8'hF0);
    send(8'h1C);
    chk_row("break_1c", 4'd2, 8'hFF);
    check_val("ev_after_1c", 32'(ev_cnt), 2);

    // extended key, then the non-extended code with an invalid entry
    map_wr(9'h175, ent(1'b1, 1'b0, 4'd0, 3'd4));
    exp_q.push_back(10'h175);
    send(8'hE0);
    send(8'h75);
    chk_row("make_e075", 4'd0, 8'hEF);
    send(8'h75);
    chk_row("bare_75", 4'd0, 8'hEF);
    check_val("ev_bare_75", 32'(ev_cnt), 3);
    exp_q.push_back(10'h375);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk_row("break_e075", 4'd0, 8'hFF);

    // frame errors
    ev0 = ev_cnt;
    err0 = err_cnt;
    send_byte(8'h1C, 1'b1, 1'b0);
    send_byte(8'h1C, 1'b0, 1'b1);
    check_val("ferr_cnt", 32'(err_cnt - err0), 2);
    check_val("ferr_noev", 32'(ev_cnt - ev0), 0);
    chk_row("ferr_row2", 4'd2, 8'hFF);

    // timeout on a truncated frame, then recovery
    err0 = err_cnt;
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    ps2 = 2'b11;
    repeat (TO + 10) @(negedge clk);
    check_val("timeout_err", 32'(err_cnt - err0), 1);
    exp_q.push_back(10'h01C);
    send(8'h1C);
    chk_row("after_to", 4'd2, 8'hDF);

    // several keys down, then overrun releases everything
    map_wr(9'h01B, ent(1'b1, 1'b0, 4'd1, 3'd3));
    map_wr(9'h023, ent(1'b1, 1'b0, 4'd9, 3'd7));
    exp_q.push_back(10'h01B);
    send(8'h1B);
    exp_q.push_back(10'h023);
    send(8'h23);
    chk_row("multi_r1", 4'd1, 8'hF7);
    chk_row("multi_r9", 4'd9, 8'h7F);
    chk_row("row_oob", 4'd12, 8'hFF);
    send(8'h00);
    chk_row("ovr_r1", 4'd1, 8'hFF);
    chk_row("ovr_r2", 4'd2, 8'hFF);
    chk_row("ovr_r9", 4'd9, 8'hFF);

    // pause sequence is swallowed whole
    ev0 = ev_cnt;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    check_val("e1_noev", 32'(ev_cnt - ev0), 0);

    // entry pointing outside the matrix still reports the event
    map_wr(9'h02B, ent(1'b1, 1'b0, 4'd12, 3'd0));
    ev0 = ev_cnt;
    exp_q.push_back(10'h02B);
    send(8'h2B);
    check_val("oob_ev", 32'(ev_cnt - ev0), 1);
    for (int r = 0; r < 10; r++) chk_row("oob_rows", 4'(r), 8'hFF);

    // special output, then reset mid-frame
    map_wr(9'h007, ent(1'b1, 1'b1, 4'd0, 3'd2));
    exp_q.push_back(10'h007);
    send(8'h07);
    check_val("fn_make", 32'(fn_w), 32'hFB);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2[1] = 1'b0;
    ps2[0] = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    ps2 = 2'b11;
    repeat (3) @(negedge clk);
    check_val("rst_fn2", 32'(fn_w), 32'hFF);
    check_val("rst_kcode2", 32'(key_code), 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    exp_q.push_back(10'h007);
    send(8'h07);
    check_val("fn_after_rst", 32'(fn_w), 32'hFB);

    check_val("sb_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
